mem_ctrl: RTL and testbench

Memory controller between the core's memory clients and the byte-wide unified RAM/IO port. It serves load/store requests from the load/store buffer and instruction-fetch requests from the fetch unit, one at a time. Each access is serialized into 1–4 single-byte RAM cycles. Loads are assembled little-endian and sign- or zero-extended, stores are split into bytes, and completion is signalled with a one-cycle pulse to the requester.

---
 rtl/mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes LSB loads/stores and instruction fetches into
// single-byte RAM/IO cycles, one access at a time.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        lsb_visit_mem,
    input  logic        work_type,
    input  logic [2:0]  word_size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        cache_ready,
    output logic        is_load,
    output logic [31:0] data_out,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, IOWAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d, last_q, last_d, size_q, size_d;
    logic        src_lsb_q, src_lsb_d, load_q, load_d, zext_q, zext_d;
    logic [31:0] base_q, base_d, wdata_q, wdata_d, asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        cache_ready_q, cache_ready_d, is_load_q, is_load_d;
    logic [31:0] data_out_q, data_out_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic [1:0]  k_inc;
    logic [31:0] next_a, asm_next, ext_val;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        last_d        = last_q;
        size_d        = size_q;
        src_lsb_d     = src_lsb_q;
        load_d        = load_q;
        zext_d        = zext_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        asm_d         = asm_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;
        data_out_d    = data_out_q;
        if_inst_d     = if_inst_q;
        cache_ready_d = 1'b0;
        if_ready_d    = 1'b0;
        is_load_d     = 1'b0;

        k_inc    = k_q + 2'd1;
        next_a   = base_q + {30'b0, k_inc};
        asm_next = asm_q;
        asm_next[{k_q, 3'b000} +: 8] = mem_din;

        case (size_q)
            2'd0:    ext_val = zext_q ? {24'b0, asm_next[7:0]}
                                      : {{24{asm_next[7]}}, asm_next[7:0]};
            2'd1:    ext_val = zext_q ? {16'b0, asm_next[15:0]}
                                      : {{16{asm_next[15]}}, asm_next[15:0]};
            default: ext_val = asm_next;
        endcase

        case (state_q)
            IDLE: begin
                if (!rob_clear_up && lsb_visit_mem) begin
                    src_lsb_d = 1'b1;
                    load_d    = work_type;
                    zext_d    = word_size[2];
                    size_d    = word_size[1:0];
                    last_d    = (word_size[1:0] == 2'd0) ? 2'd0 :
                                (word_size[1:0] == 2'd1) ? 2'd1 : 2'd3;
                    base_d    = addr;
                    wdata_d   = data_in;
                    asm_d     = 32'b0;
                    k_d       = 2'd0;
                    mem_a_d   = addr;
                    if (work_type) begin
                        state_d  = READ;
                        mem_wr_d = 1'b0;
                    end else if (addr[17:16] == 2'b11 && io_buffer_full) begin
                        state_d  = IOWAIT;
                        mem_wr_d = 1'b0;
                    end else begin
                        state_d    = WRITE;
                        mem_dout_d = data_in[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else if (!rob_clear_up && if_req) begin
                    src_lsb_d = 1'b0;
                    load_d    = 1'b1;
                    zext_d    = 1'b1;
                    size_d    = 2'd2;
                    last_d    = 2'd3;
                    base_d    = if_addr;
                    asm_d     = 32'b0;
                    k_d       = 2'd0;
                    mem_a_d   = if_addr;
                    mem_wr_d  = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                mem_wr_d = 1'b0;
                if (rob_clear_up) begin
                    state_d = IDLE;
                end else begin
                    asm_d = asm_next;
                    if (k_q == last_q) begin
                        state_d = DONE;
                        if (src_lsb_q) begin
                            cache_ready_d = 1'b1;
                            is_load_d     = load_q;
                            data_out_d    = ext_val;
                        end else begin
                            if_ready_d = 1'b1;
                            if_inst_d  = asm_next;
                        end
                    end else begin
                        k_d     = k_inc;
                        mem_a_d = next_a;
                    end
                end
            end
            WRITE: begin
                // Committed stores always finish, so flush is not looked at here.
                if (k_q == last_q) begin
                    mem_wr_d      = 1'b0;
                    state_d       = DONE;
                    cache_ready_d = 1'b1;
                    is_load_d     = load_q;
                end else begin
                    k_d        = k_inc;
                    mem_a_d    = next_a;
                    mem_dout_d = wdata_q[{k_inc, 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                end
            end
            IOWAIT: begin
                mem_wr_d = 1'b0;
                if (!io_buffer_full) begin
                    state_d    = WRITE;
                    k_d        = 2'd0;
                    mem_a_d    = base_q;
                    mem_dout_d = wdata_q[7:0];
                    mem_wr_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            k_q           <= 2'd0;
            last_q        <= 2'd0;
            size_q        <= 2'd0;
            src_lsb_q     <= 1'b0;
            load_q        <= 1'b0;
            zext_q        <= 1'b0;
            base_q        <= 32'b0;
            wdata_q       <= 32'b0;
            asm_q         <= 32'b0;
            mem_a_q       <= 32'b0;
            mem_dout_q    <= 8'b0;
            mem_wr_q      <= 1'b0;
            cache_ready_q <= 1'b0;
            is_load_q     <= 1'b0;
            data_out_q    <= 32'b0;
            if_ready_q    <= 1'b0;
            if_inst_q     <= 32'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            k_q           <= k_d;
            last_q        <= last_d;
            size_q        <= size_d;
            src_lsb_q     <= src_lsb_d;
            load_q        <= load_d;
            zext_q        <= zext_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            asm_q         <= asm_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            cache_ready_q <= cache_ready_d;
            is_load_q     <= is_load_d;
            data_out_q    <= data_out_d;
            if_ready_q    <= if_ready_d;
            if_inst_q     <= if_inst_d;
        end
    end

    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = mem_wr_q;
    assign cache_ready = cache_ready_q;
    assign is_load     = is_load_q;
    assign data_out    = data_out_q;
    assign if_ready    = if_ready_q;
    assign if_inst     = if_inst_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, vector table and scoreboard queue,
// plus hand sequences for arbitration, flush, IO stall and reset.
module tb_mem_ctrl;
    logic        clk_in, rst_in, rdy_in, rob_clear_up;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full, lsb_visit_mem, work_type;
    logic [2:0]  word_size;
    logic [31:0] addr, data_in, data_out, if_addr, if_inst;
    logic        cache_ready, is_load, if_req, if_ready;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear_up(rob_clear_up), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .lsb_visit_mem(lsb_visit_mem),
        .work_type(work_type), .word_size(word_size), .addr(addr),
        .data_in(data_in), .cache_ready(cache_ready), .is_load(is_load),
        .data_out(data_out), .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_inst(if_inst)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    logic [7:0]  ram [0:262143];
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [7:0]  pl_data;
    int          wr_cycles = 0;

    assign mem_din = ram[mem_a[17:0]];

    always @(posedge clk_in) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_wr && rdy_in) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_cycles <= wr_cycles + 1;
        end
    end

    typedef struct {
        logic        is_if;
        logic        wt;
        logic [2:0]  ws;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_v;
        int          n;
        logic [31:0] last_a;
    } vec_t;

    typedef struct {
        logic        is_if;
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] trace[$];
    logic [31:0] last_load = 32'b0;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] v);
        pl_addr = a;
        pl_data = v;
        pl_en   = 1'b1;
        @(posedge clk_in);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic is_if, input logic wt,
                         input logic [2:0] ws, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_v);
        exp_t e;
        e.is_if   = is_if;
        e.is_load = !is_if && wt;
        if (!is_if && wt) last_load = exp_v;
        e.data = (is_if || wt) ? exp_v : last_load;
        exp_q.push_back(e);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            lsb_visit_mem = 1'b1;
            work_type     = wt;
            word_size     = ws;
            addr          = a;
            data_in       = d;
        end
    endtask

    task automatic wait_done(input logic is_if, input int flush_at,
                             input int n, input logic [31:0] first_a,
                             input logic [31:0] last_a);
        exp_t e;
        bit   seen;
        int   other;
        seen  = 0;
        other = 0;
        trace.delete();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_in);
            rob_clear_up = (i == flush_at);
            if (is_if ? if_ready : cache_ready) begin
                seen = 1;
                break;
            end
            if (cache_ready || if_ready) other++;
            trace.push_back(mem_a);
        end
        rob_clear_up = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no ready pulse expected one");
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {31'b0, is_if}, {31'b0, e.is_if});
            if (is_if) begin
                chk("if_inst", if_inst, e.data);
            end else begin
                chk("data_out", data_out, e.data);
                chk("is_load", {31'b0, is_load}, {31'b0, e.is_load});
            end
        end
        chk("stray_pulse", 32'(other), 32'd0);
        if (n >= 0) begin
            chk("trace_len", 32'(trace.size()), 32'(n));
            if (trace.size() > 0) begin
                chk("first_addr", trace[0], first_a);
                chk("last_addr", trace[trace.size()-1], last_a);
            end
        end
        if (is_if) if_req = 1'b0;
        else lsb_visit_mem = 1'b0;
        @(negedge clk_in);
        chk("pulse_one_cycle", {31'b0, cache_ready | if_ready}, 32'd0);
    endtask

    int   wc0;
    int   cnt;
    exp_t drop;

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rob_clear_up = 1'b0;
        io_buffer_full = 1'b0;
        lsb_visit_mem = 1'b0;
        work_type = 1'b0;
        word_size = 3'd0;
        addr = 32'b0;
        data_in = 32'b0;
        if_req = 1'b0;
        if_addr = 32'b0;
        pl_en = 1'b0;
        pl_addr = 18'b0;
        pl_data = 8'b0;

        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h1000, 32'h0, 32'h12345678, 4, 32'h1003};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h20, 32'h0, 32'hFFFFFF80, 1, 32'h20};
        vecs[2]  = '{1'b0, 1'b1, 3'd4, 32'h20, 32'h0, 32'h00000080, 1, 32'h20};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h22, 32'h0, 32'hFFFF8001, 2, 32'h23};
        vecs[4]  = '{1'b0, 1'b1, 3'd5, 32'h22, 32'h0, 32'h00008001, 2, 32'h23};
        vecs[5]  = '{1'b0, 1'b1, 3'd1, 32'h1000, 32'h0, 32'h00005678, 2, 32'h1001};
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 32'h1003, 32'h0, 32'h00000012, 1, 32'h1003};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h00000513, 4, 32'h3};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 32'hFFFFFFFE, 32'h0, 32'h0513BBAA, 4, 32'h1};
        vecs[9]  = '{1'b0, 1'b1, 3'd4, 32'h1001, 32'h0, 32'h00000056, 1, 32'h1001};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 32'h2200, 32'h11223344, 32'h0, 1, 32'h2200};

        poke(18'h01000, 8'h78);
        poke(18'h01001, 8'h56);
        poke(18'h01002, 8'h34);
        poke(18'h01003, 8'h12);
        poke(18'h00020, 8'h80);
        poke(18'h00022, 8'h01);
        poke(18'h00023, 8'h80);
        poke(18'h00000, 8'h13);
        poke(18'h00001, 8'h05);
        poke(18'h00002, 8'h00);
        poke(18'h00003, 8'h00);
        poke(18'h3FFFE, 8'hAA);
        poke(18'h3FFFF, 8'hBB);
        poke(18'h02004, 8'h5A);
        poke(18'h00040, 8'h93);
        poke(18'h00041, 8'h00);
        poke(18'h00042, 8'h10);
        poke(18'h00043, 8'h00);

        @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_cache_ready", {31'b0, cache_ready}, 32'h0);
        chk("rst_is_load", {31'b0, is_load}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].is_if, vecs[i].wt, vecs[i].ws, vecs[i].a,
                  vecs[i].d, vecs[i].exp_v);
            wait_done(vecs[i].is_if, -1, vecs[i].n, vecs[i].a, vecs[i].last_a);
        end
        chk("sb_byte", {24'b0, ram[18'h02200]}, 32'h44);

        wc0 = wr_cycles;
        issue(1'b0, 1'b0, 3'd1, 32'h2002, 32'hABCD1234, 32'h0);
        wait_done(1'b0, -1, 2, 32'h2002, 32'h2003);
        chk("sh_wr_cycles", 32'(wr_cycles - wc0), 32'd2);
        chk("sh_b0", {24'b0, ram[18'h02002]}, 32'h34);
        chk("sh_b1", {24'b0, ram[18'h02003]}, 32'h12);
        chk("sh_untouched", {24'b0, ram[18'h02004]}, 32'h5A);

        issue(1'b0, 1'b1, 3'd2, 32'h1000, 32'h0, 32'h12345678);
        issue(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h00000513);
        wait_done(1'b0, -1, 4, 32'h1000, 32'h1003);
        wait_done(1'b1, -1, 4, 32'h0, 32'h3);

        if_req  = 1'b1;
        if_addr = 32'h40;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("flush_byte2_addr", mem_a, 32'h41);
        rob_clear_up = 1'b1;
        if_req = 1'b0;
        @(negedge clk_in);
        rob_clear_up = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (if_ready) cnt++;
        end
        chk("flush_no_ready", 32'(cnt), 32'd0);
        chk("flush_if_inst", if_inst, 32'h00000513);
        chk("flush_mem_wr", {31'b0, mem_wr}, 32'h0);
        issue(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 32'h00100093);
        wait_done(1'b1, -1, 4, 32'h40, 32'h43);

        wc0 = wr_cycles;
        issue(1'b0, 1'b0, 3'd2, 32'h2100, 32'hDEADBEEF, 32'h0);
        wait_done(1'b0, 2, 4, 32'h2100, 32'h2103);
        chk("sw_flush_wr_cycles", 32'(wr_cycles - wc0), 32'd4);
        chk("sw_flush_word", {ram[18'h02103], ram[18'h02102],
                              ram[18'h02101], ram[18'h02100]}, 32'hDEADBEEF);

        wc0 = wr_cycles;
        io_buffer_full = 1'b1;
        issue(1'b0, 1'b0, 3'd0, 32'h30000, 32'h00000077, 32'h0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (mem_wr) cnt++;
        end
        chk("io_stall_no_wr", 32'(cnt), 32'd0);
        io_buffer_full = 1'b0;
        wait_done(1'b0, -1, -1, 32'h0, 32'h0);
        chk("io_wr_cycles", 32'(wr_cycles - wc0), 32'd1);
        chk("io_byte", {24'b0, ram[18'h30000]}, 32'h77);

        issue(1'b0, 1'b1, 3'd2, 32'h1000, 32'h0, 32'h12345678);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 32'h0);
        chk("arst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("arst_data_out", data_out, 32'h0);
        chk("arst_if_inst", if_inst, 32'h0);
        chk("arst_cache_ready", {31'b0, cache_ready}, 32'h0);
        lsb_visit_mem = 1'b0;
        drop = exp_q.pop_front();
        last_load = 32'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        issue(1'b0, 1'b1, 3'd4, 32'h1001, 32'h0, 32'h00000056);
        wait_done(1'b0, -1, 1, 32'h1001, 32'h1001);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
